// File: rtl/rom_loader_if.sv
// Memory write port shared with the CPU; cpu_hold tells the memory mux
// which writer currently owns the port.
interface rom_loader_if;
  logic        cpu_hold;
  logic        mem_write;
  logic [11:0] mem_write_addr;
  logic [7:0]  mem_write_data;

  modport master (output cpu_hold, output mem_write, output mem_write_addr, output mem_write_data);
  modport slave  (input  cpu_hold, input  mem_write, input  mem_write_addr, input  mem_write_data);
endinterface

// File: rtl/rom_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked ROM image over UART
// and writes it into memory while holding the CPU.
module rom_loader #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [11:0] LOAD_BASE    = 12'h200,
  parameter int          IDLE_TIMEOUT = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         uart_rx,
  rom_loader_if.master mem,
  output logic         load_done,
  output logic         load_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [16:0]   MAX_LEN   = 17'(4096) - {5'd0, LOAD_BASE};

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_LEN_HI, WAIT_LEN_LO, DATA, WAIT_CHK, DONE} state_t;

  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          byte_valid_reg, byte_valid_next;
  logic          frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg   <= RX_IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      rx_state_reg   <= rx_state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      byte_valid_reg <= byte_valid_next;
    end
  end

  // frame_err is combinational at the stop-bit sample so the error flag
  // lands exactly one cycle later, like every other error source.
  always_comb begin
    rx_state_next   = rx_state_reg;
    cnt_next        = cnt_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    frame_err       = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          cnt_next      = '0;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next      = '0;
          bit_next      = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync_reg, shift_reg[7:1]};
          if (bit_reg == 3'd7) rx_state_next = RX_STOP;
          else                 bit_next      = bit_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          rx_state_next = RX_IDLE;
          if (rx_sync_reg) byte_valid_next = 1'b1;
          else             frame_err       = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  state_t        state_reg, state_next;
  logic [7:0]    len_hi_reg, len_hi_next;
  logic [15:0]   len_reg, len_next;
  logic [15:0]   idx_reg, idx_next;
  logic [7:0]    chk_reg, chk_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic          hold_reg, hold_next, wr_reg, wr_next, done_reg, done_next, err_reg, err_next;
  logic [11:0]   addr_reg, addr_next;
  logic [7:0]    data_reg, data_next;
  logic [15:0]   len_word;

  assign len_word = {len_hi_reg, shift_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= WAIT_LEN_HI;
      len_hi_reg <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      chk_reg    <= '0;
      idle_reg   <= '0;
      hold_reg   <= 1'b1;
      wr_reg     <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      len_hi_reg <= len_hi_next;
      len_reg    <= len_next;
      idx_reg    <= idx_next;
      chk_reg    <= chk_next;
      idle_reg   <= idle_next;
      hold_reg   <= hold_next;
      wr_reg     <= wr_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    len_hi_next = len_hi_reg;
    len_next    = len_reg;
    idx_next    = idx_reg;
    chk_next    = chk_reg;
    idle_next   = idle_reg;
    hold_next   = hold_reg;
    wr_next     = 1'b0;
    addr_next   = addr_reg;
    data_next   = data_reg;
    done_next   = done_reg;
    err_next    = err_reg;
    case (state_reg)
      WAIT_LEN_HI: if (byte_valid_reg) begin
        len_hi_next = shift_reg;
        err_next    = 1'b0;
        state_next  = WAIT_LEN_LO;
      end
      WAIT_LEN_LO: if (byte_valid_reg) begin
        len_next = len_word;
        idx_next = '0;
        chk_next = '0;
        if ({1'b0, len_word} > MAX_LEN) begin
          err_next   = 1'b1;
          state_next = WAIT_LEN_HI;
        end else if (len_word == 16'd0) begin
          state_next = WAIT_CHK;
        end else begin
          state_next = DATA;
        end
      end
      DATA: if (byte_valid_reg) begin
        wr_next   = 1'b1;
        addr_next = LOAD_BASE + idx_reg[11:0];
        data_next = shift_reg;
        chk_next  = chk_reg ^ shift_reg;
        idx_next  = idx_reg + 16'd1;
        if (idx_reg + 16'd1 == len_reg) state_next = WAIT_CHK;
      end
      WAIT_CHK: if (byte_valid_reg) begin
        if (shift_reg == chk_reg) begin
          done_next  = 1'b1;
          hold_next  = 1'b0;
          state_next = DONE;
        end else begin
          err_next   = 1'b1;
          state_next = WAIT_LEN_HI;
        end
      end
      default: ;
    endcase

    // A byte arriving in the expiry cycle clears the counter, so it wins.
    if (state_reg inside {WAIT_LEN_LO, DATA, WAIT_CHK}) begin
      if (byte_valid_reg) begin
        idle_next = '0;
      end else if (idle_reg == IDLE_LAST) begin
        idle_next  = '0;
        err_next   = 1'b1;
        state_next = WAIT_LEN_HI;
      end else begin
        idle_next = idle_reg + 1'b1;
      end
    end else begin
      idle_next = '0;
    end

    if (frame_err && state_reg != DONE) begin
      err_next   = 1'b1;
      state_next = WAIT_LEN_HI;
    end
  end

  assign mem.cpu_hold       = hold_reg;
  assign mem.mem_write      = wr_reg;
  assign mem.mem_write_addr = addr_reg;
  assign mem.mem_write_data = data_reg;
  assign load_done          = done_reg;
  assign load_error         = err_reg;
endmodule

// File: tb/tb_rom_loader.sv
// Randomized frame-level bench for rom_loader against a byte-stream parsing model.
module tb_rom_loader;
  localparam int          CPB  = 8;
  localparam logic [11:0] BASE = 12'hF00;
  localparam int          TO   = 3000;
  localparam int          MAXN = 4096 - int'(BASE);

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic load_done, load_error;

  rom_loader_if bus ();

  rom_loader #(.CLKS_PER_BIT(CPB), .LOAD_BASE(BASE), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .mem(bus),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  logic wr_prev = 1'b0;
  logic [19:0] got_w[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every write; a strobe must never last two cycles.
  always @(negedge clk) begin
    if (bus.mem_write) begin
      got_w.push_back({bus.mem_write_addr, bus.mem_write_data});
      last_wr_cyc = cyc;
      total++;
      assert (wr_prev === 1'b0) else begin
        bad++;
        $error("FAIL wr_pulse got=multi-cycle strobe at addr %0h exp=single cycle", bus.mem_write_addr);
      end
    end
    wr_prev = bus.mem_write;
  end

  // Reference model: parse the received byte stream as frames.
  logic [7:0]  pend[$];
  bit          m_done = 0;
  bit          m_err = 0;
  logic [19:0] exp_w[$];

  task automatic model_byte(input logic [7:0] b);
    int n;
    logic [7:0] x;
    if (m_done) return;
    pend.push_back(b);
    if (pend.size() == 1) begin
      m_err = 0;
    end else begin
      n = int'({pend[0], pend[1]});
      if (pend.size() == 2) begin
        if (n > MAXN) begin
          m_err = 1;
          pend.delete();
        end
      end else if (pend.size() <= n + 2) begin
        exp_w.push_back({12'(int'(BASE) + pend.size() - 3), b});
      end else begin
        x = 8'h00;
        for (int i = 2; i < n + 2; i++) x ^= pend[i];
        if (x == b) m_done = 1;
        else        m_err = 1;
        pend.delete();
      end
    end
  endtask

  task automatic model_abort();
    if (!m_done) begin
      m_err = 1;
      pend.delete();
    end
  endtask

  function automatic bq_t make_frame(input int n, input bit good);
    bq_t f;
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      x ^= b;
      f.push_back(b);
    end
    f.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic uart_tx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    uart_tx(b, 1'b1);
    model_byte(b);
  endtask

  task automatic send_all(input bq_t f);
    foreach (f[i]) send(f[i]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_nwr"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) chk({tag, "_wr"}, got_w[i], exp_w[i]);
    chk({tag, "_done"}, load_done, m_done);
    chk({tag, "_err"}, load_error, m_err);
    chk({tag, "_hold"}, bus.cpu_hold, !m_done);
    $display("step %s: writes=%0d done=%0b err=%0b", tag, got_w.size(), load_done, load_error);
    got_w.delete();
    exp_w.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hold"}, bus.cpu_hold, 1);
    chk({tag, "_wr"}, bus.mem_write, 0);
    chk({tag, "_addr"}, bus.mem_write_addr, 0);
    chk({tag, "_data"}, bus.mem_write_data, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, load_error, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    pend.delete();
    exp_w.delete();
    got_w.delete();
    m_done = 0;
    m_err = 0;
  endtask

  bq_t f;

  initial begin
    @(negedge clk);
    do_reset();
    check_reset_vals("reset");

    f = make_frame($urandom_range(1, 8), 1);
    send_all(f);
    check_all("nominal");

    do_reset();
    f = make_frame($urandom_range(2, 8), 0);
    send_all(f);
    check_all("badchk");
    f[f.size() - 1] = 8'h00;
    for (int i = 2; i < f.size() - 1; i++) f[f.size() - 1] ^= f[i];
    send(f[0]);
    chk("resend_errclr", load_error, m_err);
    for (int i = 1; i < f.size(); i++) send(f[i]);
    check_all("resend");

    do_reset();
    send(8'(MAXN + 1 >> 8));
    send(8'(MAXN + 1));
    check_all("len_over");
    f = make_frame(MAXN, 1);
    send_all(f);
    chk("last_addr", got_w.size() > 0 ? 32'(got_w[got_w.size() - 1][19:8]) : 32'hFFFF_FFFF, 12'hFFF);
    check_all("len_max");

    do_reset();
    send(8'h00);
    uart_tx(8'($urandom), 1'b0);
    model_abort();
    check_all("framing");
    send(8'h00);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_err", load_error, 0);
    f = make_frame(2, 1);
    for (int i = 1; i < f.size(); i++) send(f[i]);
    check_all("glitch_frame");

    do_reset();
    send(8'h00);
    send(8'h05);
    send(8'h01);
    while (cyc < last_wr_cyc + TO - 10) @(negedge clk);
    chk("to_early", load_error, 0);
    while (cyc < last_wr_cyc + TO + 10) @(negedge clk);
    chk("to_late", load_error, 1);
    model_abort();
    check_all("timeout");
    f = make_frame($urandom_range(1, 6), 1);
    send_all(f);
    check_all("after_to");

    do_reset();
    send(8'h00);
    send(8'h04);
    send(8'($urandom));
    check_all("pre_rst");
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    reset = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    pend.delete();
    exp_w.delete();
    got_w.delete();
    m_done = 0;
    m_err = 0;
    f = make_frame($urandom_range(1, 6), 1);
    send_all(f);
    check_all("post_rst");

    do_reset();
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check_all("empty");
    for (int i = 0; i < 3; i++) send(8'($urandom));
    uart_tx(8'h3C, 1'b0);
    check_all("done_lock");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
